// File: rtl/prefetch_pkg.sv
// ============================================================================
// Module : prefetch_pkg
// Brief  : Shared AR request payload type and arbiter state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package prefetch_pkg;

    localparam int c_ADDR_BITS       = 64;
    localparam int c_BURST_LEN_WIDTH = 8;
    localparam int c_TID_WIDTH       = 8;

    typedef struct packed {
        logic [c_ADDR_BITS-1:0]       addr;
        logic [c_BURST_LEN_WIDTH-1:0] len;
        logic [c_TID_WIDTH-1:0]       id;
    } ar_req_t;

    typedef enum logic [1:0] {
        S_EMPTY    = 2'd0,
        S_HOLD_DMD = 2'd1,
        S_HOLD_PF  = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_updown_cnt.sv
// ============================================================================
// Module : sat_updown_cnt
// Brief  : Up/down counter saturating at zero and all-ones, with sync clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_updown_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Simultaneous inc and dec cancel; clear dominates both.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && !(&r_count)) begin
            r_count <= r_count + WIDTH'(1);
        end else if (i_dec && !i_inc && (|r_count)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/prefetch_ar_arbiter.sv
// ============================================================================
// Module : prefetch_ar_arbiter
// Brief  : Demand/prefetch AR arbiter with starvation guard and prefetch cap.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module prefetch_ar_arbiter
    import prefetch_pkg::*;
#(
    parameter int ADDR_BITS       = c_ADDR_BITS,
    parameter int BURST_LEN_WIDTH = c_BURST_LEN_WIDTH,
    parameter int TID_WIDTH       = c_TID_WIDTH,
    parameter int CNT_WIDTH       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 dmd_valid,
    output logic                 dmd_ready,
    input  ar_req_t              dmd_req,
    input  logic                 pf_valid,
    output logic                 pf_ready,
    input  ar_req_t              pf_req,
    output logic                 m_ar_valid,
    input  logic                 m_ar_ready,
    output ar_req_t              m_ar_req,
    output logic                 m_ar_is_pf,
    input  logic                 pf_done,
    input  logic [CNT_WIDTH-1:0] crs_starve_limit,
    input  logic [CNT_WIDTH-1:0] crs_pf_max_out,
    output logic [CNT_WIDTH-1:0] pf_outstanding
);

    // The payload type lives in the package, so the widths must agree with it.
    generate
        if (ADDR_BITS + BURST_LEN_WIDTH + TID_WIDTH != $bits(ar_req_t)) begin : g_width_check
            $error("prefetch_ar_arbiter: payload widths disagree with ar_req_t");
        end
    endgenerate

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    ar_req_t              r_req;
    logic [CNT_WIDTH-1:0] w_starve_cnt;
    logic                 w_slot_free;
    logic                 w_pf_elig;
    logic                 w_pf_wins;
    logic                 w_dmd_acc;
    logic                 w_pf_acc;

    assign w_slot_free = !m_ar_valid || m_ar_ready;
    assign w_pf_elig   = pf_valid && !flush && (pf_outstanding < crs_pf_max_out);
    assign w_pf_wins   = w_pf_elig && (!dmd_valid || (w_starve_cnt >= crs_starve_limit));
    assign dmd_ready   = !reset && en && w_slot_free && !w_pf_wins;
    assign pf_ready    = !reset && en && w_slot_free && w_pf_wins;
    assign w_dmd_acc   = dmd_valid && dmd_ready;
    assign w_pf_acc    = pf_valid && pf_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_dmd_acc) begin
            w_state_nxt = S_HOLD_DMD;
        end else if (w_pf_acc) begin
            w_state_nxt = S_HOLD_PF;
        end else if (m_ar_valid && m_ar_ready) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_comb begin
        m_ar_valid = (r_state != S_EMPTY);
        m_ar_is_pf = (r_state == S_HOLD_PF);
        m_ar_req   = r_req;
    end

    // Payload only loads on an accept, so it is stable under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req <= '0;
        end else if (w_dmd_acc) begin
            r_req <= dmd_req;
        end else if (w_pf_acc) begin
            r_req <= pf_req;
        end
    end

    sat_updown_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_starve_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_pf_acc || flush || !pf_valid),
        .i_inc   (w_dmd_acc && w_pf_elig),
        .i_dec   (1'b0),
        .o_count (w_starve_cnt)
    );

    // Flush leaves this alone: bursts already issued still return data.
    sat_updown_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_pf_out_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (1'b0),
        .i_inc   (w_pf_acc),
        .i_dec   (pf_done),
        .o_count (pf_outstanding)
    );

endmodule

`default_nettype wire

// File: tb/tb_prefetch_ar_arbiter.sv
// ============================================================================
// Module : tb_prefetch_ar_arbiter
// Brief  : Directed self-checking bench for the prefetch AR arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_prefetch_ar_arbiter;
    import prefetch_pkg::*;

    logic       clk = 1'b0;
    logic       reset, en, flush;
    logic       dmd_valid, dmd_ready, pf_valid, pf_ready;
    ar_req_t    dmd_req, pf_req, m_ar_req;
    logic       m_ar_valid, m_ar_ready, m_ar_is_pf, pf_done;
    logic [3:0] crs_starve_limit, crs_pf_max_out, pf_outstanding;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prefetch_ar_arbiter #(
        .ADDR_BITS       (64),
        .BURST_LEN_WIDTH (8),
        .TID_WIDTH       (8),
        .CNT_WIDTH       (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .en               (en),
        .flush            (flush),
        .dmd_valid        (dmd_valid),
        .dmd_ready        (dmd_ready),
        .dmd_req          (dmd_req),
        .pf_valid         (pf_valid),
        .pf_ready         (pf_ready),
        .pf_req           (pf_req),
        .m_ar_valid       (m_ar_valid),
        .m_ar_ready       (m_ar_ready),
        .m_ar_req         (m_ar_req),
        .m_ar_is_pf       (m_ar_is_pf),
        .pf_done          (pf_done),
        .crs_starve_limit (crs_starve_limit),
        .crs_pf_max_out   (crs_pf_max_out),
        .pf_outstanding   (pf_outstanding)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        reset = 1'b1; en = 1'b1; flush = 1'b0; pf_done = 1'b0;
        dmd_valid = 1'b1; pf_valid = 1'b0; m_ar_ready = 1'b1;
        dmd_req = '0; pf_req = '0;
        dmd_req.addr = 64'hD000; dmd_req.id = 8'h11;
        pf_req.addr  = 64'hF000; pf_req.id  = 8'h22;
        crs_starve_limit = 4'd3; crs_pf_max_out = 4'd8;

        // Reset: outputs idle, readies forced low even with en and dmd_valid high
        step(); step();
        check("rst_valid", m_ar_valid, 1'b0);
        check("rst_pf_out", pf_outstanding, 4'd0);
        check("rst_dmd_ready", dmd_ready, 1'b0);
        check("rst_pf_ready", pf_ready, 1'b0);
        reset = 1'b0;

        // Starvation: limit 3 -> D,D,D,P,D,D,D,P
        pf_valid = 1'b1;
        pat = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            settle();
            check($sformatf("starve_pf_ready%0d", i), pf_ready, pat[i]);
            check($sformatf("starve_dmd_ready%0d", i), dmd_ready, !pat[i]);
            step();
            check($sformatf("starve_is_pf%0d", i), m_ar_is_pf, pat[i]);
            check($sformatf("starve_addr%0d", i), m_ar_req.addr, pat[i] ? 64'hF000 : 64'hD000);
        end
        check("starve_pf_out", pf_outstanding, 4'd2);
        dmd_valid = 1'b0; pf_valid = 1'b0; pf_done = 1'b1;
        step(); step();
        pf_done = 1'b0;
        step();
        check("starve_drain_out", pf_outstanding, 4'd0);
        check("starve_drain_valid", m_ar_valid, 1'b0);

        // Outstanding cap of 2
        crs_pf_max_out = 4'd2; pf_valid = 1'b1;
        settle(); check("cap_acc1", pf_ready, 1'b1); step();
        settle(); check("cap_acc2", pf_ready, 1'b1); step();
        settle(); check("cap_block", pf_ready, 1'b0);
        check("cap_out2", pf_outstanding, 4'd2);
        pf_done = 1'b1;
        settle(); check("cap_block_done", pf_ready, 1'b0);
        step();
        pf_done = 1'b0;
        check("cap_out1", pf_outstanding, 4'd1);
        settle(); check("cap_acc3", pf_ready, 1'b1);
        step();
        check("cap_out_final", pf_outstanding, 4'd2);
        pf_valid = 1'b0; pf_done = 1'b1;
        step(); step();
        pf_done = 1'b0;
        check("cap_drain", pf_outstanding, 4'd0);

        // Simultaneous accept and pf_done
        crs_pf_max_out = 4'd8; pf_valid = 1'b1;
        step();
        check("sim_out1", pf_outstanding, 4'd1);
        pf_done = 1'b1;
        settle(); check("sim_pf_ready", pf_ready, 1'b1);
        step();
        check("sim_both", pf_outstanding, 4'd1);
        pf_valid = 1'b0;
        step();
        check("sim_dec", pf_outstanding, 4'd0);
        step();
        check("sim_floor", pf_outstanding, 4'd0);
        pf_done = 1'b0;

        // Backpressure: held 0x1000 stays for 5 cycles, released on the 6th
        m_ar_ready = 1'b0; dmd_req.addr = 64'h1000; dmd_valid = 1'b1;
        settle(); check("bp_acc", dmd_ready, 1'b1);
        step();
        check("bp_valid", m_ar_valid, 1'b1);
        check("bp_addr", m_ar_req.addr, 64'h1000);
        dmd_req.addr = 64'h2000;
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("bp_ready%0d", i), dmd_ready, 1'b0);
            check($sformatf("bp_hold%0d", i), m_ar_req.addr, 64'h1000);
            step();
        end
        m_ar_ready = 1'b1;
        settle(); check("bp_release", dmd_ready, 1'b1);
        step();
        check("bp_next_addr", m_ar_req.addr, 64'h2000);
        check("bp_next_is_pf", m_ar_is_pf, 1'b0);
        dmd_valid = 1'b0;
        step();
        check("bp_empty", m_ar_valid, 1'b0);

        // Flush with a prefetch held: held one issues, no new prefetch, demand unaffected
        m_ar_ready = 1'b0; pf_valid = 1'b1;
        settle(); check("fl_pf_acc", pf_ready, 1'b1);
        step();
        check("fl_held_pf", m_ar_is_pf, 1'b1);
        check("fl_out1", pf_outstanding, 4'd1);
        flush = 1'b1; m_ar_ready = 1'b1; dmd_valid = 1'b1; dmd_req.addr = 64'h3000;
        settle();
        check("fl_pf_ready", pf_ready, 1'b0);
        check("fl_dmd_ready", dmd_ready, 1'b1);
        check("fl_held_valid", m_ar_valid, 1'b1);
        step();
        check("fl_dmd_is_pf", m_ar_is_pf, 1'b0);
        check("fl_dmd_addr", m_ar_req.addr, 64'h3000);
        check("fl_out_kept", pf_outstanding, 4'd1);
        flush = 1'b0; dmd_valid = 1'b0; pf_valid = 1'b0; pf_done = 1'b1;
        step();
        pf_done = 1'b0;
        step();
        check("fl_drain", pf_outstanding, 4'd0);

        // Reset mid-hold discards the held prefetch and clears counters
        m_ar_ready = 1'b0; pf_valid = 1'b1;
        settle(); check("rh_pf_acc", pf_ready, 1'b1);
        step();
        pf_valid = 1'b0; dmd_valid = 1'b1;
        step();
        check("rh_held", m_ar_valid, 1'b1);
        check("rh_out1", pf_outstanding, 4'd1);
        reset = 1'b1;
        settle();
        check("rh_dmd_ready", dmd_ready, 1'b0);
        check("rh_pf_ready", pf_ready, 1'b0);
        step();
        check("rh_valid", m_ar_valid, 1'b0);
        check("rh_is_pf", m_ar_is_pf, 1'b0);
        check("rh_out0", pf_outstanding, 4'd0);
        check("rh_addr", m_ar_req.addr, 64'h0);
        reset = 1'b0;

        // Starve counter restarts from zero: limit 1 -> D then P
        crs_starve_limit = 4'd1; m_ar_ready = 1'b1; pf_valid = 1'b1;
        settle(); check("post_d", dmd_ready, 1'b1);
        step();
        settle(); check("post_p", pf_ready, 1'b1);
        step();
        check("post_is_pf", m_ar_is_pf, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
